// File: rtl/mc_controller.sv
// mc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS datapath with retired-instruction counter
module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  output logic [2:0]       ALUSrc,
  output logic [2:0]       ExtOp,
  output logic [2:0]       ALUControl,
  output logic [2:0]       RegWrite,
  output logic [2:0]       MemWrite,
  output logic [2:0]       RegDst,
  output logic [2:0]       nPCSel,
  output logic [2:0]       RegWriteSel,
  output logic [2:0]       DataExtOp,
  output logic             PCWrite,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t state_q, state_d;
  logic [5:0] op_q, op_d, func_q, func_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_nop, is_valid, is_short, active, last;
  // instruction decode from the latched opcode/function fields
  always_comb begin
    is_addu  = op_q == 6'h00 && func_q == 6'h21;
    is_subu  = op_q == 6'h00 && func_q == 6'h23;
    is_jr    = op_q == 6'h00 && func_q == 6'h08;
    is_nop   = op_q == 6'h00 && func_q == 6'h00;
    is_ori   = op_q == 6'h0D;
    is_lui   = op_q == 6'h0F;
    is_lw    = op_q == 6'h23;
    is_sw    = op_q == 6'h2B;
    is_beq   = op_q == 6'h04;
    is_j     = op_q == 6'h02;
    is_jal   = op_q == 6'h03;
    is_valid = is_addu | is_subu | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal;
    is_short = is_j | is_jr | !is_valid;
  end
  // next state, operand latch on leaving FETCH, and retire counting on the last state
  always_comb begin
    last      = (state_q == DECODE && is_short) || (state_q == EXEC && is_beq) ||
                (state_q == MEM && is_sw) || state_q == WB;
    state_d   = state_q == FETCH  ? DECODE :
                state_q == DECODE ? (is_short ? FETCH : is_jal ? WB : EXEC) :
                state_q == EXEC   ? (is_beq ? FETCH : (is_lw | is_sw) ? MEM : WB) :
                state_q == MEM    ? (is_sw ? FETCH : WB) : FETCH;
    op_d      = state_q == FETCH ? Op : op_q;
    func_d    = state_q == FETCH ? Func : func_q;
    retired_d = retired_q + CNT_W'(last);
  end
  // state, latched instruction fields and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      op_q      <= '0;
      func_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      func_q    <= func_d;
      retired_q <= retired_d;
    end
  end
  // datapath selects held from DECODE on; write enables only in the final state
  always_comb begin
    active      = state_q != FETCH;
    ALUSrc      = active && (is_ori | is_lui | is_lw | is_sw) ? 3'd1 : 3'd0;
    ExtOp       = !active ? 3'd0 : is_lui ? 3'd2 : (is_lw | is_sw) ? 3'd1 : 3'd0;
    ALUControl  = !active ? 3'd0 : (is_subu | is_beq) ? 3'd1 : is_ori ? 3'd2 : 3'd0;
    RegDst      = !active ? 3'd0 : (is_addu | is_subu) ? 3'd1 : is_jal ? 3'd2 : 3'd0;
    RegWriteSel = !active ? 3'd0 : is_lw ? 3'd1 : is_jal ? 3'd2 : 3'd0;
    nPCSel      = !last ? 3'd0 : is_beq ? 3'd1 : (is_j | is_jal) ? 3'd2 : is_jr ? 3'd3 : 3'd0;
    RegWrite    = {2'b00, state_q == WB};
    MemWrite    = {2'b00, state_q == MEM && is_sw};
    DataExtOp   = 3'd0;
    PCWrite     = last;
    illegal     = state_q == DECODE && !is_valid && !is_nop;
    retired     = retired_q;
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller
module tb_mc_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] Op = '0, Func = '0;
  logic [2:0] ALUSrc, ExtOp, ALUControl, RegWrite, MemWrite, RegDst, nPCSel, RegWriteSel, DataExtOp;
  logic PCWrite, illegal;
  logic [31:0] retired;
  logic [28:0] ctrl;
  int n_checks = 0, n_fail = 0;
  logic [28:0] q_ctrl[$];
  logic [31:0] q_ret[$];
  logic [31:0] exp_ret = '0;

  mc_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Func(Func),
    .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUControl(ALUControl), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .RegDst(RegDst), .nPCSel(nPCSel), .RegWriteSel(RegWriteSel),
    .DataExtOp(DataExtOp), .PCWrite(PCWrite), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  assign ctrl = {ALUSrc, ExtOp, ALUControl, RegWrite, MemWrite, RegDst, nPCSel, RegWriteSel, DataExtOp, PCWrite, illegal};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] vec(input int a, e, alu, rw, mw, rd, npc, rws, pcw, ill);
    return {3'(a), 3'(e), 3'(alu), 3'(rw), 3'(mw), 3'(rd), 3'(npc), 3'(rws), 3'd0, 1'(pcw), 1'(ill)};
  endfunction

  task automatic expect_instr(input logic [5:0] op, input logic [5:0] func);
    int n = 2, a = 0, e = 0, alu = 0, rd = 0, rws = 0, npc = 0;
    bit wb = 0, memw = 0, ill = 0;
    if (op == 6'h00 && func == 6'h21) begin n = 4; rd = 1; wb = 1; end
    else if (op == 6'h00 && func == 6'h23) begin n = 4; rd = 1; alu = 1; wb = 1; end
    else if (op == 6'h00 && func == 6'h08) begin n = 2; npc = 3; end
    else if (op == 6'h0D) begin n = 4; a = 1; alu = 2; wb = 1; end
    else if (op == 6'h0F) begin n = 4; a = 1; e = 2; wb = 1; end
    else if (op == 6'h23) begin n = 5; a = 1; e = 1; rws = 1; wb = 1; end
    else if (op == 6'h2B) begin n = 4; a = 1; e = 1; memw = 1; end
    else if (op == 6'h04) begin n = 3; alu = 1; npc = 1; end
    else if (op == 6'h02) begin n = 2; npc = 2; end
    else if (op == 6'h03) begin n = 3; npc = 2; rd = 2; rws = 2; wb = 1; end
    else ill = !(op == 6'h00 && func == 6'h00);
    for (int c = 0; c < n; c++) begin
      bit lst = c == n - 1;
      q_ret.push_back(exp_ret);
      if (c == 0) q_ctrl.push_back('0);
      else q_ctrl.push_back(vec(a, e, alu, int'(wb && lst), int'(memw && lst), rd,
                                lst ? npc : 0, rws, int'(lst), int'(ill && c == 1)));
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] func, input int abort);
    expect_instr(op, func);
    Op = op;
    Func = func;
    for (int c = 0; q_ctrl.size() > 0; c++) begin
      if (c == abort) begin
        reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
          check({name, "_rst_ctrl"}, 64'(ctrl), 64'd0);
          check({name, "_rst_ret"}, 64'(retired), 64'd0);
          if (k < 2) @(negedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check({name, "_post_rst_ctrl"}, 64'(ctrl), 64'd0);
        q_ctrl.delete();
        q_ret.delete();
        exp_ret = '0;
        return;
      end
      check({name, "_ctrl"}, 64'(ctrl), 64'(q_ctrl.pop_front()));
      check({name, "_ret"}, 64'(retired), 64'(q_ret.pop_front()));
      @(posedge clk);
      #1;
      Op = 6'($urandom);
      Func = 6'($urandom);
      @(negedge clk);
    end
    exp_ret++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_ctrl", 64'(ctrl), 64'd0);
    check("reset_ret", 64'(retired), 64'd0);
    reset = 1'b1;
    run_instr("addu", 6'h00, 6'h21, -1);
    run_instr("addu_abort", 6'h00, 6'h21, 3);
    run_instr("addu2", 6'h00, 6'h21, -1);
    run_instr("lw", 6'h23, 6'h00, -1);
    run_instr("sw", 6'h2B, 6'h15, -1);
    run_instr("subu", 6'h00, 6'h23, -1);
    run_instr("ori", 6'h0D, 6'h3F, -1);
    run_instr("lui", 6'h0F, 6'h00, -1);
    run_instr("beq", 6'h04, 6'h00, -1);
    run_instr("j", 6'h02, 6'h00, -1);
    run_instr("jal", 6'h03, 6'h00, -1);
    run_instr("jr", 6'h00, 6'h08, -1);
    run_instr("illegal_op", 6'h3F, 6'h00, -1);
    run_instr("nop", 6'h00, 6'h00, -1);
    run_instr("illegal_func", 6'h00, 6'h3F, -1);
    check("count", 64'(retired), 64'(exp_ret));
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    exp_ret = 32'hFFFF_FFFF;
    run_instr("wrap_addu", 6'h00, 6'h21, -1);
    check("wrap", 64'(retired), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
